// File: rtl/sat_alu_pipe.sv
// sat_alu_pipe: two-stage saturating ALU with valid/ready handshake; define SAT_ALU_FLAGS_EN for the flags register
module sat_alu_pipe #(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovfl,
    output logic [2:0]       flags
);
    localparam int SH_W = $clog2(WIDTH);
    localparam int NL   = WIDTH / LANE_W;
    localparam int NB   = WIDTH / 8;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_XOR = 3'd2, OP_RED = 3'd3,
                           OP_SLL = 3'd4, OP_SRA = 3'd5, OP_ROR = 3'd6;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic               s1_valid, s2_adv;
    logic [2:0]         s1_op;
    logic [WIDTH-1:0]   s1_a, s1_b;
    logic [WIDTH:0]     sum, dif;
    logic [LANE_W:0]    lsum;
    logic [WIDTH-1:0]   pres, acc, res;
    logic [2*WIDTH-1:0] rot;
    logic [SH_W-1:0]    sh;
    logic               povf, ovfl;

    assign s2_adv   = !out_valid | out_ready;
    assign in_ready = !s1_valid | s2_adv;

    // result of the operand set held in S1; saturation uses one guard bit
    always_comb begin
        sh   = s1_b[SH_W-1:0];
        sum  = {s1_a[WIDTH-1], s1_a} + {s1_b[WIDTH-1], s1_b};
        dif  = {s1_a[WIDTH-1], s1_a} - {s1_b[WIDTH-1], s1_b};
        rot  = {s1_a, s1_a} >> sh;
        pres = '0;
        povf = 1'b0;
        lsum = '0;
        for (int i = 0; i < NL; i++) begin
            lsum = {s1_a[i*LANE_W+LANE_W-1], s1_a[i*LANE_W +: LANE_W]}
                 + {s1_b[i*LANE_W+LANE_W-1], s1_b[i*LANE_W +: LANE_W]};
            pres[i*LANE_W +: LANE_W] = (lsum[LANE_W] != lsum[LANE_W-1])
                ? {lsum[LANE_W], {(LANE_W-1){~lsum[LANE_W]}}} : lsum[LANE_W-1:0];
            povf = povf | (lsum[LANE_W] ^ lsum[LANE_W-1]);
        end
        acc = '0;
        for (int i = 0; i < NB; i++)
            acc = acc + WIDTH'($signed(s1_a[8*i +: 8])) + WIDTH'($signed(s1_b[8*i +: 8]));
        res  = '0;
        ovfl = 1'b0;
        case (s1_op)
            OP_ADD: begin
                ovfl = sum[WIDTH] ^ sum[WIDTH-1];
                res  = ovfl ? (sum[WIDTH] ? SAT_MIN : SAT_MAX) : sum[WIDTH-1:0];
            end
            OP_SUB: begin
                ovfl = dif[WIDTH] ^ dif[WIDTH-1];
                res  = ovfl ? (dif[WIDTH] ? SAT_MIN : SAT_MAX) : dif[WIDTH-1:0];
            end
            OP_XOR: res = s1_a ^ s1_b;
            OP_RED: res = acc;
            OP_SLL: res = s1_a << sh;
            OP_SRA: res = $unsigned($signed(s1_a) >>> sh);
            OP_ROR: res = rot[WIDTH-1:0];
            default: begin
                res  = pres;
                ovfl = povf;
            end
        endcase
    end

    // S1: capture operands whenever the stage is free or draining into S2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= op;
                s1_a  <= a;
                s1_b  <= b;
            end
        end
    end

    // S2: register the result; holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovfl  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= res;
                out_ovfl <= ovfl;
            end
        end
    end

`ifdef SAT_ALU_FLAGS_EN
    // {Z,V,N} of the most recently consumed result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flags <= 3'b000;
        else if (out_valid && out_ready)
            flags <= {out_data == '0, out_ovfl, out_data[WIDTH-1]};
    end
`else
    assign flags = 3'b000;
`endif
endmodule

// File: doc/sat_alu_pipe.md
SAT_ALU_PIPE -- requirements
Module: sat_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; SHALL be a multiple of 8 and of LANE_W, minimum 8.
REQ-002 Parameter LANE_W, default 4, lane width for PADDSB in bits; SHALL be at least 2.
REQ-003 Port clk  input  1  rising-edge clock, sole clock.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  operand set present.
REQ-006 Port in_ready  output  1  operand set accepted when in_valid & in_ready.
REQ-007 Port op  input  3  opcode: 000 ADD, 001 SUB, 010 XOR, 011 RED, 100 SLL, 101 SRA, 110 ROR, 111 PADDSB.
REQ-008 Port a, b  input  WIDTH each  operands, two's complement.
REQ-009 Port out_valid  output  1  result present.
REQ-010 Port out_ready  input  1  result consumed when out_valid & out_ready.
REQ-011 Port out_data  output  WIDTH  result.
REQ-012 Port out_ovfl  output  1  saturation occurred for this result.
REQ-013 Port flags  output  3  {Z,V,N} of last consumed result.

Function
REQ-014 Two register stages (S1 operand/op capture, S2 result); result SHALL appear on out_data 2 cycles after acceptance when unstalled; throughput 1 per cycle.
REQ-015 S2 advances when !out_valid | out_ready; S1 advances when S1 empty or S2 advances; in_ready = S1 empty | S1 advancing (combinational from out_ready, no bubble).
REQ-016 out_data/out_ovfl SHALL hold stable while out_valid & !out_ready; no result dropped or duplicated; order preserved.
REQ-017 ADD/SUB: a+b / a-b, WIDTH-bit signed saturating; positive overflow -> 0111..1, negative -> 1000..0, out_ovfl=1.
REQ-018 PADDSB: independent WIDTH/LANE_W lanes, each LANE_W-bit signed saturating add, no inter-lane carry; out_ovfl = OR of lane overflows.
REQ-019 XOR: a^b, out_ovfl=0.
REQ-020 RED: signed sum of all 2*WIDTH/8 bytes of a and b, sign-extended to WIDTH, never saturates, out_ovfl=0.
REQ-021 SLL/SRA/ROR: shift a by b[$clog2(WIDTH)-1:0]; SRA sign-fills, ROR rotates right; amount 0 passes a; out_ovfl=0.
REQ-022 Simultaneous consume at S2 and accept at S1 in the same cycle SHALL both occur.

Reset
REQ-023 On rst_n low, immediately: out_valid=0, S1 empty, out_data=0, out_ovfl=0, flags=000; in_ready=1 after release.
REQ-024 Reset mid-operation discards all in-flight results; none SHALL emerge after release.

Configuration
REQ-025 Macro SAT_ALU_FLAGS_EN defined: flags register updates on each consumed result: Z=(out_data==0), V=out_ovfl, N=out_data[WIDTH-1]; unchanged otherwise.
REQ-026 SAT_ALU_FLAGS_EN undefined: flags port present, tied to 000, no flag registers.

Verification (WIDTH=16, LANE_W=4, out_ready=1 unless stated)
REQ-027 ADD a=7FFF b=0001 -> out_data 7FFF, out_ovfl 1, out_valid exactly 2 cycles after acceptance; with flags enabled flags=010 after consume.
REQ-028 SUB a=8000 b=0001 -> 8000, ovfl 1; SUB a=0005 b=0005 -> 0000, ovfl 0, flags Z=1.
REQ-029 PADDSB a=7878 b=1111 -> 7979, ovfl 1; RED a=7F01 b=80FF -> FFFF, ovfl 0.
REQ-030 SRA a=8000 b=0004 -> F800; ROR a=8001 b=0001 -> C000; SLL a=0001 b=000F -> 8000.
REQ-031 Four back-to-back ADDs with out_ready low 3 cycles -> in_ready deasserts after 2 held, all 4 results emerge in order, values unchanged during stall.
REQ-032 rst_n pulsed low with 2 ops in flight -> out_valid 0 same cycle, flags 000, no stale result after release.
